// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: definitions shared by the UART receiver and the future
// transmitter.
//   - uart_state_t     : receiver FSM state encodings
//   - DATA_BITS/FRAME_BITS : 8N1 frame geometry
//   - DEFAULT_*        : default clock and baud rate
//   - clks_per_bit()   : integer clock cycles per bit time
package uart_rx_pkg;

  localparam int DATA_BITS           = 8;
  localparam int FRAME_BITS          = 10;
  localparam int DEFAULT_CLK_FREQ_HZ = 12_000_000;
  localparam int DEFAULT_BAUD_RATE   = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input.
//   clk       : destination clock
//   rst_n     : asynchronous active-low reset
//   d         : asynchronous input
//   q         : synchronized output (two clk cycles of latency)
// RESET_VAL sets the value both flops take in reset, so an idle-high line
// does not look like an edge when reset is released.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RESET_VAL;
      q       <= RESET_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte valid/ready holding register.
//   CLK       : clock, all logic on the rising edge
//   RESET     : asynchronous active-low reset
//   RXD       : serial input, idle high, asynchronous to CLK
//   rx_data   : last accepted byte, stable while rx_valid is high
//   rx_valid  : a byte is waiting in the holding register
//   rx_ready  : consumer takes the byte when rx_valid & rx_ready
//   frame_err : one-cycle pulse in the cycle the stop bit samples low
//   overrun   : sticky, a good byte was dropped because the holder was full
//   err_clr   : clears overrun on the next edge (a simultaneous set wins)
//   busy      : receiver is not idle
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int BAUD_RATE   = DEFAULT_BAUD_RATE
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(FRAME_BITS);

  // Counters run down to zero; zero marks the sample cycle.
  localparam logic [CNT_W-1:0] HALF_LOAD     = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE       = BIT_W'(1);

  if (CLKS_PER_BIT < 4) begin : g_cfg_check
    $error("uart_rx: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
  end

  logic                 rxd_s;
  uart_state_t          state, state_nxt;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic                 sample;
  logic                 shift_en;
  logic                 good_stop;
  logic                 load_ok;
  logic                 drop;

  // Input synchronizer stage
  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (RESET),
    .d     (RXD),
    .q     (rxd_s)
  );

  assign sample = (clk_cnt == '0);
  assign busy   = (state != ST_IDLE);

  // FSM next-state and strobes
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_en    = 1'b0;
    good_stop   = 1'b0;
    frame_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_nxt   = ST_START;
          clk_cnt_nxt = HALF_LOAD;
        end
      end
      ST_START: begin
        if (sample) begin
          if (rxd_s) begin
            // Line went back high before mid-bit: treat as a glitch.
            state_nxt = ST_IDLE;
          end else begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
            clk_cnt_nxt = BIT_LOAD;
          end
        end else begin
          clk_cnt_nxt = clk_cnt - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_en    = 1'b1;
          clk_cnt_nxt = BIT_LOAD;
          bit_cnt_nxt = bit_cnt + BIT_ONE;
          if (bit_cnt == LAST_DATA_BIT) begin
            state_nxt = ST_STOP;
          end
        end else begin
          clk_cnt_nxt = clk_cnt - CNT_ONE;
        end
      end
      ST_STOP: begin
        if (sample) begin
          bit_cnt_nxt = bit_cnt + BIT_ONE;
          if (rxd_s) begin
            good_stop = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = ST_BREAK;
          end
        end else begin
          clk_cnt_nxt = clk_cnt - CNT_ONE;
        end
      end
      ST_BREAK: begin
        // Stay here while the line is held low so a break is not re-read
        // as a string of start bits.
        if (rxd_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Shift register: LSB arrives first, so shift right in at the top.
  always_ff @(posedge CLK) begin
    if (shift_en) begin
      shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
    end
  end

  // Holding register stage
  assign load_ok = good_stop && (!rx_valid || rx_ready);
  assign drop    = good_stop && rx_valid && !rx_ready;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load_ok) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
// Stimulus pushes the expected byte and the cycle it must appear; a monitor
// on the falling edge pops and compares whenever a new byte is presented or
// frame_err pulses.
module tb_uart_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 16;
  // RXD driven just after edge k reaches rxd_s at cycle k+2 (= T0);
  // stop sample at T0+152, byte visible at T0+153.
  localparam int LAT_VALID = 2 + 153;
  localparam int LAT_FERR  = 2 + 152;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       RXD = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .RXD       (RXD),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   fe_q[$];
  exp_t cur;
  int   fe_cyc;
  int   n_checks = 0;
  int   n_pass = 0;
  int   valid_cycles = 0;
  logic prev_valid = 1'b0;
  logic prev_accept = 1'b0;
  logic [9:0] abort_bits;
  int   k0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives one full frame; entered and left just after a rising edge.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      RXD = bits[b];
      tick(CPB);
    end
  endtask

  task automatic send_good(input logic [7:0] data, input logic expect_it);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + LAT_VALID;
    if (expect_it) sb_q.push_back(e);
    send_frame(data, 1'b1);
  endtask

  // Monitor
  always @(negedge CLK) begin
    if (rx_valid) valid_cycles++;
    if (rx_valid && (!prev_valid || prev_accept)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_byte: got rx_data=%02h, required no byte", rx_data);
      end else begin
        cur = sb_q.pop_front();
        check("rx_data", {24'h0, rx_data}, {24'h0, cur.data});
        check("rx_valid_cycle", cyc, cur.cyc);
        check("busy_at_valid", {31'h0, busy}, 32'h0);
      end
    end
    if (frame_err) begin
      if (fe_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame_err: got pulse at cycle %0d, required none", cyc);
      end else begin
        fe_cyc = fe_q.pop_front();
        check("frame_err_cycle", cyc, fe_cyc);
      end
    end
    prev_valid  = rx_valid;
    prev_accept = rx_valid && rx_ready;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    // Reset values
    tick(3);
    check("reset_rx_data", {24'h0, rx_data}, 32'h0);
    check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_overrun", {31'h0, overrun}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    RESET = 1'b1;
    tick(5);

    // 0xA5 held until rx_ready is pulsed
    send_good(8'hA5, 1'b1);
    check("a5_hold_valid", {31'h0, rx_valid}, 32'h1);
    tick(20);
    check("a5_hold_valid_late", {31'h0, rx_valid}, 32'h1);
    check("a5_hold_data_late", {24'h0, rx_data}, 32'hA5);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("a5_valid_after_accept", {31'h0, rx_valid}, 32'h0);

    // Glitch: 4 cycles low is rejected at the mid-start sample
    tick(5);
    RXD = 1'b0;
    tick(4);
    RXD = 1'b1;
    check("glitch_busy_high", {31'h0, busy}, 32'h1);
    tick(10);
    check("glitch_busy_low", {31'h0, busy}, 32'h0);
    check("glitch_no_valid", {31'h0, rx_valid}, 32'h0);
    tick(30);

    // 0x3C with a low stop bit, line then held low for 50 more cycles
    k0 = cyc;
    fe_q.push_back(k0 + LAT_FERR);
    send_frame(8'h3C, 1'b0);
    tick(45);
    check("break_busy", {31'h0, busy}, 32'h1);
    check("break_no_valid", {31'h0, rx_valid}, 32'h0);
    tick(5);
    RXD = 1'b1;
    tick(5);
    check("break_released_idle", {31'h0, busy}, 32'h0);
    check("break_no_valid_after", {31'h0, rx_valid}, 32'h0);
    tick(30);

    // Overrun: 0x11 then 0x22 back-to-back, nobody reading
    check("overrun_before", {31'h0, overrun}, 32'h0);
    send_good(8'h11, 1'b1);
    send_good(8'h22, 1'b0);
    check("overrun_set", {31'h0, overrun}, 32'h1);
    check("overrun_data_kept", {24'h0, rx_data}, 32'h11);
    check("overrun_valid", {31'h0, rx_valid}, 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("overrun_cleared", {31'h0, overrun}, 32'h0);
    check("overrun_data_after_clr", {24'h0, rx_data}, 32'h11);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(20);

    // rx_ready tied high: three back-to-back bytes, one valid cycle each
    valid_cycles = 0;
    rx_ready = 1'b1;
    send_good(8'h00, 1'b1);
    send_good(8'hFF, 1'b1);
    send_good(8'h5A, 1'b1);
    tick(20);
    check("tied_valid_cycles", valid_cycles, 3);
    check("tied_no_overrun", {31'h0, overrun}, 32'h0);
    rx_ready = 1'b0;
    tick(5);

    // Reset during data bit 4 of 0xC3, with 0x96 waiting in the holder
    send_good(8'h96, 1'b1);
    tick(5);
    abort_bits = {1'b1, 8'hC3, 1'b0};
    for (int b = 0; b < 5; b++) begin
      RXD = abort_bits[b];
      tick(CPB);
    end
    RXD = abort_bits[5];
    tick(8);
    check("abort_busy_before", {31'h0, busy}, 32'h1);
    RESET = 1'b0;
    #1;
    check("abort_rx_data", {24'h0, rx_data}, 32'h0);
    check("abort_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_overrun", {31'h0, overrun}, 32'h0);
    check("abort_frame_err", {31'h0, frame_err}, 32'h0);
    RXD = 1'b1;
    tick(3);
    RESET = 1'b1;
    tick(20);

    // Clean frame after reset
    rx_ready = 1'b1;
    send_good(8'h7E, 1'b1);
    tick(20);
    rx_ready = 1'b0;

    check("byte_queue_drained", sb_q.size(), 0);
    check("frame_err_queue_drained", fe_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
